// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store unit.
package lsu_pkg;
    localparam int WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, load extract/extend and store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offs_i,
    input  logic [WORD_W-1:0] rd_word_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              legal_o,
    output logic [WORD_W-1:0] load_data_o,
    output logic [WORD_W-1:0] store_data_o
);
    logic [4:0]        sh_amt;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] wlane;

    assign sh_amt  = {offs_i, 3'b000};
    assign shifted = rd_word_i >> sh_amt;

    always_comb begin
        case (funct3_i)
            F3_B:    legal_o = 1'b1;
            F3_H:    legal_o = ~offs_i[0];
            F3_W:    legal_o = (offs_i == 2'b00);
            F3_BU:   legal_o = ~we_i;
            F3_HU:   legal_o = ~we_i & ~offs_i[0];
            default: legal_o = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3_i)
            F3_B:    load_data_o = {{(WORD_W-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data_o = {{(WORD_W-8){1'b0}}, shifted[7:0]};
            F3_H:    load_data_o = {{(WORD_W-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data_o = {{(WORD_W-16){1'b0}}, shifted[15:0]};
            default: load_data_o = rd_word_i;
        endcase
    end

    // Sub-word data is replicated across lanes so the shifted mask alone picks the target.
    always_comb begin
        mask  = '1;
        wlane = wdata_i;
        case (funct3_i)
            F3_B: begin
                mask  = {{(WORD_W-8){1'b0}}, 8'hFF} << sh_amt;
                wlane = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                mask  = {{(WORD_W-16){1'b0}}, 16'hFFFF} << sh_amt;
                wlane = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
        store_data_o = (rd_word_i & ~mask) | (wlane & mask);
    end
endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: request latch, IDLE/ACCESS/RESP FSM, read-modify-write for sub-word stores.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH) + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [WIDTH-1:0] mem_rd_dout,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_din,
    output logic             mem_we
);
    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             mem_we_q, mem_we_d;
    logic             req_ready_q, req_ready_d;

    logic             idle;
    logic             al_we;
    logic [2:0]       al_f3;
    logic [1:0]       al_offs;
    logic             al_legal;
    logic [WIDTH-1:0] al_load;
    logic [WIDTH-1:0] al_store;

    // In IDLE the checker looks at the incoming request; afterwards at the latched one.
    assign idle    = (state_q == IDLE);
    assign al_we   = idle ? req_we : we_q;
    assign al_f3   = idle ? req_funct3 : f3_q;
    assign al_offs = idle ? req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .we_i         (al_we),
        .funct3_i     (al_f3),
        .offs_i       (al_offs),
        .rd_word_i    (mem_rd_dout),
        .wdata_i      (wdata_q),
        .legal_o      (al_legal),
        .load_data_o  (al_load),
        .store_data_o (al_store)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        rdata_d      = rdata_q;
        mem_we_d     = 1'b0;
        req_ready_d  = req_ready_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    f3_d        = req_funct3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (al_legal) begin
                        state_d  = ACCESS;
                        mem_we_d = req_we;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        rdata_d      = '0;
                    end
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                rdata_d      = we_q ? '0 : al_load;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            mem_we_q     <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
            mem_we_q     <= mem_we_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = rdata_q;
    assign mem_we      = mem_we_q;
    assign mem_rd_addr = {addr_q[AW-1:2], 2'b00};
    assign mem_wr_addr = {addr_q[AW-1:2], 2'b00};
    assign mem_wr_din  = al_store;
endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: attached word memory, directed vector table, stall/reset sequences, random run vs model.
module tb_lsu_rmw;
    localparam int AW = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0] mem_rd_dout;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0] mem_wr_din;
    logic        mem_we;

    logic [31:0] mem [DEPTH];
    logic        pre_we = 1'b0;
    int          pre_idx = 0;
    logic [31:0] pre_data = '0;
    int          we_cycles = 0;

    logic [31:0] ref_mem [DEPTH];
    int          exp_writes = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lsu_rmw #(.WIDTH(32), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
        .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din), .mem_we(mem_we)
    );

    assign mem_rd_dout = mem[mem_rd_addr[AW-1:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (mem_we) begin
            mem[mem_wr_addr[AW-1:2]] <= mem_wr_din;
        end
    end

    always @(negedge clk) if (rst && mem_we) we_cycles <= we_cycles + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-granular view of the memory, computed straight from the access rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int idx, off, size;
        logic [31:0] w, msk;
        idx = int'(a) / 4;
        off = int'(a) % 4;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: size = we ? 0 : 1;
            3'd5: size = we ? 0 : 2;
            default: size = 0;
        endcase
        err = (size == 0) ? 1'b1 : ((off % size) != 0);
        rd = '0;
        if (err) return;
        w = ref_mem[idx];
        if (we) begin
            for (int b = off; b < off + size; b++) w[8*b +: 8] = wd[8*(b-off) +: 8];
            ref_mem[idx] = w;
            exp_writes++;
        end else begin
            msk = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 1);
            rd = (w >> (8*off)) & msk;
            if ((f3 == 3'd0 || f3 == 3'd1) && rd[8*size-1]) rd = rd | ~msk;
        end
    endfunction

    task automatic txn(input logic we, input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output int wes,
                       output logic [31:0] wdin);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wes = 0; wdin = '0;
        while (!resp_valid && lat < 20) begin
            if (mem_we) begin wes++; wdin = mem_wr_din; end
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_wdin;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] rd, mrd, wdin;
        logic er, merr, rwe;
        logic [2:0] rf3;
        logic [AW-1:0] ra;
        logic [31:0] rwd;
        int lat, wes;

        vecs[0]  = '{1'b0, 3'd0, 4'd1,  32'h0,  32'h0000_007F, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'd4, 4'd1,  32'h0,  32'h0000_007F, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 3'd0, 4'd2,  32'h0,  32'hFFFF_FF81, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'd4, 4'd2,  32'h0,  32'h0000_0081, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 3'd0, 4'd6,  32'hAB, 32'h0,         1'b0, 32'h11AB_3344};
        vecs[5]  = '{1'b0, 3'd2, 4'd4,  32'h0,  32'h11AB_3344, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 3'd1, 4'd10, 32'hBEEF, 32'h0,       1'b0, 32'hBEEF_0000};
        vecs[7]  = '{1'b0, 3'd1, 4'd10, 32'h0,  32'hFFFF_BEEF, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 3'd5, 4'd10, 32'h0,  32'h0000_BEEF, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 3'd2, 4'd2,  32'h0,  32'h0,         1'b1, 32'h0};
        vecs[10] = '{1'b1, 3'd1, 4'd3,  32'h5555, 32'h0,       1'b1, 32'h0};
        vecs[11] = '{1'b0, 3'd3, 4'd0,  32'h0,  32'h0,         1'b1, 32'h0};
        vecs[12] = '{1'b1, 3'd4, 4'd0,  32'h77, 32'h0,         1'b1, 32'h0};

        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk) rst = 1'b1;

        ref_mem[0] = 32'h8081_7F01; ref_mem[1] = 32'h1122_3344; ref_mem[2] = '0; ref_mem[3] = '0;
        pre_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pre_idx = i; pre_data = ref_mem[i];
            @(negedge clk);
        end
        pre_we = 1'b0;

        for (int i = 0; i < 13; i++) begin
            txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat, wes, wdin);
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, mrd, merr);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_err ? 0 : 1);
            chk($sformatf("vec%0d_we_cycles", i), wes, (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
            if (vecs[i].we && !vecs[i].exp_err)
                chk($sformatf("vec%0d_wr_din", i), wdin, vecs[i].exp_wdin);
        end
        chk("err_mem0_unchanged", mem[0], 32'h8081_7F01);
        chk("err_mem1_unchanged", mem[1], 32'h11AB_3344);

        // Response stall: consumer holds off for 5 cycles while new requests are offered.
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 4'd4;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        chk("stall_valid_first", {31'b0, resp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 4'd4; req_wdata = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            chk($sformatf("stall%0d_valid", k), {31'b0, resp_valid}, 32'd1);
            chk($sformatf("stall%0d_rdata", k), resp_rdata, 32'h11AB_3344);
            chk($sformatf("stall%0d_req_ready", k), {31'b0, req_ready}, 32'd0);
            chk($sformatf("stall%0d_mem_we", k), {31'b0, mem_we}, 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", {31'b0, resp_valid}, 32'd0);
        chk("release_req_ready", {31'b0, req_ready}, 32'd1);
        txn(1'b0, 3'd2, 4'd4, 32'h0, rd, er, lat, wes, wdin);
        chk("stall_ignored_store", rd, 32'h11AB_3344);

        for (int i = 0; i < 200; i++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = AW'($urandom_range(0, 15));
            rwd = $urandom;
            txn(rwe, rf3, ra, rwd, rd, er, lat, wes, wdin);
            model(rwe, rf3, ra, rwd, mrd, merr);
            chk($sformatf("rnd%0d_rdata", i), rd, mrd);
            chk($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, merr});
            chk($sformatf("rnd%0d_latency", i), lat, merr ? 0 : 1);
        end
        for (int i = 0; i < DEPTH; i++) chk($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);
        chk("total_write_cycles", we_cycles, exp_writes);

        // Reset in the middle of a store's ACCESS cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 4'd12; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 req_valid = 1'b0;
        chk("rstacc_we_before", {31'b0, mem_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstacc_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rstacc_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rstacc_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rstacc_rdata", resp_rdata, 32'd0);
        chk("rstacc_wr_addr", {28'b0, mem_wr_addr}, 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        txn(1'b0, 3'd2, 4'd12, 32'h0, rd, er, lat, wes, wdin);
        chk("rstacc_lw_after", rd, 32'd0);
        chk("rstacc_lw_err", {31'b0, er}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
